// File: rtl/ibex_ex_fu_sequencer.sv
// EX-stage sequencer: routes single-cycle ALU results or one of NumFu multi-cycle unit results to ID.
// Optional BUSY watchdog enabled by defining IBEX_EX_FU_TIMEOUT_EN.
module ibex_ex_fu_sequencer #(
  parameter int unsigned NumFu         = 2,
  parameter int unsigned Width         = 32,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fu_en_i,
  input  logic [NumFu-1:0]       fu_sel_i,
  input  logic [NumFu-1:0]       fu_valid_i,
  input  logic [NumFu*Width-1:0] fu_result_i,
  input  logic [Width-1:0]       alu_result_i,
  input  logic                   alu_valid_i,
  input  logic                   ready_id_i,
  input  logic                   kill_i,
  output logic [NumFu-1:0]       fu_start_o,
  output logic [Width-1:0]       result_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   sel_error_o,
  output logic                   timeout_o
);

  localparam int unsigned IdxW = (NumFu > 1) ? $clog2(NumFu) : 1;
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IdxW-1:0]  r_idx;
  logic [IdxW-1:0]  w_sel_idx;
  logic [Width-1:0] r_hold;
  logic [Width-1:0] w_hold_d;
  logic [Width-1:0] w_fu_res;
  logic             w_fu_done;
  logic             w_sel_onehot;
  logic             w_sel_multi;
  logic             w_tmo_hit;
  logic             w_idx_load;
  logic             w_hold_load;
  logic             w_busy_enter;

  // Select decode and latched-unit result/strobe mux
  always_comb begin
    w_sel_idx = '0;
    w_fu_done = 1'b0;
    w_fu_res  = '0;
    for (int k = 0; k < NumFu; k++) begin
      if (fu_sel_i[k]) begin
        w_sel_idx = IdxW'(k);
      end
      if (r_idx == IdxW'(k)) begin
        w_fu_done = fu_valid_i[k];
        w_fu_res  = fu_result_i[k*Width +: Width];
      end
    end
  end

  assign w_sel_onehot = (fu_sel_i != '0) && ((fu_sel_i & (fu_sel_i - NumFu'(1))) == '0);
  assign w_sel_multi  = (fu_sel_i != '0) && !w_sel_onehot;

`ifdef IBEX_EX_FU_TIMEOUT_EN
  logic [CntW-1:0] r_tcnt;

  // Counts BUSY cycles since the last start; completion is forced at TmoLast
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tcnt <= '0;
    end else if (w_busy_enter) begin
      r_tcnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_tcnt <= r_tcnt + CntW'(1);
    end
  end

  assign w_tmo_hit = (r_state == S_BUSY) && !w_fu_done && (r_tcnt == TmoLast);
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^TmoLast;
  assign w_tmo_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and outputs; kill overrides everything else
  always_comb begin
    w_state_nxt  = r_state;
    fu_start_o   = '0;
    result_o     = alu_result_i;
    valid_o      = 1'b0;
    sel_error_o  = 1'b0;
    timeout_o    = 1'b0;
    w_idx_load   = 1'b0;
    w_hold_load  = 1'b0;
    w_busy_enter = 1'b0;
    w_hold_d     = '0;
    if (rst_ni) begin
      sel_error_o = fu_en_i && w_sel_multi;
      case (r_state)
        S_IDLE: begin
          if (fu_sel_i == '0) begin
            valid_o = alu_valid_i;
          end else if (fu_en_i && w_sel_onehot) begin
            fu_start_o   = fu_sel_i;
            w_idx_load   = 1'b1;
            w_busy_enter = 1'b1;
            w_state_nxt  = S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_fu_done || w_tmo_hit) begin
            valid_o   = 1'b1;
            timeout_o = w_tmo_hit;
            w_hold_d  = w_fu_done ? w_fu_res : '0;
            result_o  = w_hold_d;
            if (ready_id_i) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_hold_load = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          valid_o  = 1'b1;
          result_o = r_hold;
          if (ready_id_i) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
      if (kill_i) begin
        valid_o      = 1'b0;
        fu_start_o   = '0;
        timeout_o    = 1'b0;
        w_idx_load   = 1'b0;
        w_hold_load  = 1'b0;
        w_busy_enter = 1'b0;
        w_state_nxt  = S_IDLE;
      end
    end
  end

  // Latched unit index and stalled-result hold register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx  <= '0;
      r_hold <= '0;
    end else begin
      if (w_idx_load) begin
        r_idx <= w_sel_idx;
      end
      if (w_hold_load) begin
        r_hold <= w_hold_d;
      end
    end
  end

  assign busy_o = (r_state == S_BUSY) || (r_state == S_HOLD);

endmodule
